// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, the captured
// request record and a saturating counter helper.
package mem_arb_types;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_MASK_W = ARB_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_A = 3'd1,
    BUSY_B = 3'd2,
    RESP_A = 3'd3,
    RESP_B = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_MASK_W-1:0] wmask;
    logic                  rd;
    logic                  wr;
  } arb_req_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// Two-requester round-robin select: a lone requester always wins, and on a
// tie the requester that did not win last time is chosen.
module rr_select (
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant_a,
  output logic grant_b
);

  // last_grant = 1 means B won the previous grant, so A is favoured now.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (req_a && req_b) begin
      grant_a = last_grant;
      grant_b = ~last_grant;
    end else begin
      grant_a = req_a;
      grant_b = req_b;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes the instruction port (A) and data port (B) onto one word-level
// downstream port, returning a one-cycle response to the owning port.
module mem_port_arbiter
  import mem_arb_types::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter bit RESET_PRIO_B = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_a,
  input  logic [ADDR_WIDTH-1:0]   address_a,
  output logic [DATA_WIDTH-1:0]   rdata_a,
  output logic                    resp_a,
  input  logic                    read_b,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address_b,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  output logic [DATA_WIDTH-1:0]   rdata_b,
  output logic                    resp_b,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp,
  output logic [31:0]             conflict_cnt
);

  localparam int MASK_W = DATA_WIDTH / 8;

  arb_state_t            r_state;
  arb_req_t              r_req;
  logic                  r_last_grant;
  logic                  r_busy;
  logic                  r_resp_a;
  logic                  r_resp_b;
  logic [DATA_WIDTH-1:0] r_rdata_a;
  logic [DATA_WIDTH-1:0] r_rdata_b;
  logic [31:0]           r_conflict_cnt;

  logic w_req_a;
  logic w_req_b;
  logic w_grant_a;
  logic w_grant_b;

  assign w_req_a = read_a;
  assign w_req_b = read_b | write;

  rr_select u_rr_select (
    .req_a      (w_req_a),
    .req_b      (w_req_b),
    .last_grant (r_last_grant),
    .grant_a    (w_grant_a),
    .grant_b    (w_grant_b)
  );

  // Arbitration FSM; every output comes from a register set here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_last_grant   <= ~RESET_PRIO_B;
      r_req          <= '0;
      r_busy         <= 1'b0;
      r_resp_a       <= 1'b0;
      r_resp_b       <= 1'b0;
      r_rdata_a      <= '0;
      r_rdata_b      <= '0;
      r_conflict_cnt <= 32'd0;
    end else begin
      r_resp_a <= 1'b0;
      r_resp_b <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_a && w_req_b) begin
            r_conflict_cnt <= sat_inc32(r_conflict_cnt);
          end
          // last_grant tracks every grant, not only contested ones.
          if (w_grant_b) begin
            r_req.addr   <= ARB_ADDR_W'(address_b);
            r_req.wdata  <= ARB_DATA_W'(wdata);
            r_req.wmask  <= ARB_MASK_W'(wmask);
            r_req.rd     <= ~write;
            r_req.wr     <= write;
            r_busy       <= 1'b1;
            r_last_grant <= 1'b1;
            r_state      <= BUSY_B;
          end else if (w_grant_a) begin
            r_req.addr   <= ARB_ADDR_W'(address_a);
            r_req.wdata  <= '0;
            r_req.wmask  <= '0;
            r_req.rd     <= 1'b1;
            r_req.wr     <= 1'b0;
            r_busy       <= 1'b1;
            r_last_grant <= 1'b0;
            r_state      <= BUSY_A;
          end
        end
        BUSY_A: begin
          if (mem_resp) begin
            r_rdata_a <= mem_rdata;
            r_busy    <= 1'b0;
            r_resp_a  <= 1'b1;
            r_state   <= RESP_A;
          end
        end
        BUSY_B: begin
          if (mem_resp) begin
            r_rdata_b <= r_req.wr ? '0 : mem_rdata;
            r_busy    <= 1'b0;
            r_resp_b  <= 1'b1;
            r_state   <= RESP_B;
          end
        end
        RESP_A, RESP_B: begin
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_read     = r_busy & r_req.rd;
  assign mem_write    = r_busy & r_req.wr;
  assign mem_address  = ADDR_WIDTH'(r_req.addr);
  assign mem_wdata    = DATA_WIDTH'(r_req.wdata);
  assign mem_wmask    = MASK_W'(r_req.wmask);
  assign rdata_a      = r_rdata_a;
  assign rdata_b      = r_rdata_b;
  assign resp_a       = r_resp_a;
  assign resp_b       = r_resp_b;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_a;
  logic [31:0] address_a;
  logic [31:0] rdata_a;
  logic        resp_a;
  logic        read_b;
  logic        write;
  logic [31:0] address_b;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata_b;
  logic        resp_b;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic [31:0] conflict_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PRIO_B(1'b1)) dut (
    .clk(clk), .rst(rst),
    .read_a(read_a), .address_a(address_a), .rdata_a(rdata_a), .resp_a(resp_a),
    .read_b(read_b), .write(write), .address_b(address_b), .wdata(wdata),
    .wmask(wmask), .rdata_b(rdata_b), .resp_b(resp_b),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .conflict_cnt(conflict_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Transaction model: which port has an access in flight, which port is
  // being answered this cycle, and the last request handed downstream.
  int              m_owner;   // 0 none, 1 A, 2 B
  int              m_resp;    // 0 none, 1 A, 2 B
  bit              m_last_b;
  longint unsigned m_cnt;
  logic [31:0]     m_addr;
  logic [31:0]     m_wdata;
  logic [3:0]      m_wmask;
  bit              m_wr;
  logic [31:0]     m_rdata_a;
  logic [31:0]     m_rdata_b;

  logic [31:0] mem [0:255];
  int          forced_delay;
  int          mem_wait;
  bit          stale_en;

  task automatic model_reset();
    m_owner   = 0;
    m_resp    = 0;
    m_last_b  = 1'b0;   // B is favoured first after reset
    m_cnt     = 0;
    m_addr    = 32'd0;
    m_wdata   = 32'd0;
    m_wmask   = 4'd0;
    m_wr      = 1'b0;
    m_rdata_a = 32'd0;
    m_rdata_b = 32'd0;
    mem_wait  = 0;
  endtask

  task automatic model_edge();
    bit want_a;
    bit want_b;
    int pick;
    want_a = read_a;
    want_b = read_b | write;
    pick   = 0;
    if (m_resp != 0) begin
      m_resp = 0;
    end else if (m_owner != 0) begin
      if (mem_resp) begin
        if (m_owner == 1) m_rdata_a = mem_rdata;
        else m_rdata_b = m_wr ? 32'd0 : mem_rdata;
        m_resp  = m_owner;
        m_owner = 0;
      end
    end else begin
      if (want_a && want_b) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
        pick = m_last_b ? 1 : 2;
      end else if (want_a) pick = 1;
      else if (want_b) pick = 2;
      if (pick == 1) begin
        m_addr = address_a; m_wdata = 32'd0; m_wmask = 4'd0; m_wr = 1'b0;
      end else if (pick == 2) begin
        m_addr = address_b; m_wdata = wdata; m_wmask = wmask; m_wr = write;
      end
      if (pick != 0) begin
        m_owner  = pick;
        m_last_b = (pick == 2);
        mem_wait = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, 3));
      end
    end
  endtask

  // Advance one clock: update the model at the edge, then drive the memory side.
  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    mem_rdata = $urandom;
    mem_resp  = 1'b0;
    if (m_owner != 0) begin
      if (mem_wait == 0) begin
        mem_resp = 1'b1;
        if (m_wr) begin
          for (int b = 0; b < 4; b++)
            if (m_wmask[b]) mem[m_addr[9:2]][8*b +: 8] = m_wdata[8*b +: 8];
        end else begin
          mem_rdata = mem[m_addr[9:2]];
        end
      end else begin
        mem_wait = mem_wait - 1;
      end
    end else begin
      mem_resp = stale_en && ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin : cmp
    logic [167:0] e_v;
    logic [167:0] a_v;
    e_v = {(m_resp == 1), (m_resp == 2), (m_owner != 0 && !m_wr), (m_owner != 0 && m_wr),
           m_wmask, m_addr, m_wdata, m_rdata_a, m_rdata_b, m_cnt[31:0]};
    a_v = {resp_a, resp_b, mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
           rdata_a, rdata_b, conflict_cnt};
    vectors = vectors + 1;
    if (a_v !== e_v) begin
      miscompares = miscompares + 1;
      $display("FAIL cycle_outputs t=%0t: got %h, expected %h", $time, a_v, e_v);
    end
  end

  initial begin : stim
    bit a_pend;
    bit b_pend;
    int kind;
    int n;
    int order;
    rst = 1'b1;
    read_a = 1'b0; address_a = 32'd0;
    read_b = 1'b0; write = 1'b0; address_b = 32'd0; wdata = 32'd0; wmask = 4'd0;
    mem_rdata = 32'd0; mem_resp = 1'b0;
    forced_delay = 0; stale_en = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    model_reset();
    step(); step(); step();
    chk("reset conflict_cnt", conflict_cnt, 32'd0);
    chk("reset mem_read", {31'd0, mem_read}, 32'd0);
    #2 rst = 1'b0;

    // A-only read of 0x60, memory answers in the second strobe cycle.
    mem[24] = 32'h0000_0013; forced_delay = 1;
    read_a = 1'b1; address_a = 32'h0000_0060;
    step(); chk("A c1 mem_read", {31'd0, mem_read}, 32'd1);
    chk("A c1 mem_address", mem_address, 32'h0000_0060);
    step(); chk("A c2 mem_read", {31'd0, mem_read}, 32'd1);
    step(); chk("A c3 resp_a", {31'd0, resp_a}, 32'd1);
    chk("A c3 rdata_a", rdata_a, 32'h0000_0013);
    chk("A c3 mem_read", {31'd0, mem_read}, 32'd0);
    chk("A c3 resp_b", {31'd0, resp_b}, 32'd0);
    read_a = 1'b0;
    step(); chk("A c4 resp_a", {31'd0, resp_a}, 32'd0);
    chk("A conflict_cnt", conflict_cnt, 32'd0);

    // B masked write.
    forced_delay = 0;
    write = 1'b1; address_b = 32'h0000_1004; wdata = 32'hDEAD_BEEF; wmask = 4'b0011;
    step(); chk("Bw mem_write", {31'd0, mem_write}, 32'd1);
    chk("Bw mem_read", {31'd0, mem_read}, 32'd0);
    chk("Bw mem_wmask", {28'd0, mem_wmask}, 32'd3);
    chk("Bw mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("Bw mem_address", mem_address, 32'h0000_1004);
    step(); chk("Bw resp_b", {31'd0, resp_b}, 32'd1);
    chk("Bw rdata_b", rdata_b, 32'd0);
    write = 1'b0;
    step(); chk("Bw resp_b once", {31'd0, resp_b}, 32'd0);

    // read_b+write together is a write; address change while busy is ignored.
    forced_delay = 2;
    read_b = 1'b1; write = 1'b1; address_b = 32'h0000_2000; wdata = 32'h1234_5678; wmask = 4'hF;
    step(); chk("Brw mem_write", {31'd0, mem_write}, 32'd1);
    chk("Brw mem_read", {31'd0, mem_read}, 32'd0);
    address_b = 32'h0000_3000;
    step(); chk("Bhold c2 mem_address", mem_address, 32'h0000_2000);
    step(); chk("Bhold c3 mem_address", mem_address, 32'h0000_2000);
    step(); chk("Brw resp_b", {31'd0, resp_b}, 32'd1);
    read_b = 1'b0; write = 1'b0;
    step();

    // Both ports requesting continuously from reset: B, A, B, A.
    rst = 1'b1; model_reset();
    forced_delay = 0;
    read_a = 1'b1; address_a = 32'h0000_0040;
    read_b = 1'b1; address_b = 32'h0000_2000;
    step(); #2 rst = 1'b0;
    n = 0; order = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      step();
      if (resp_a || resp_b) begin
        order = (order << 1) | int'(resp_b);
        n = n + 1;
        if (n == 4) chk("RR conflict_cnt", conflict_cnt, 32'd4);
      end
    end
    chk("RR responses", n, 32'd4);
    chk("RR order", order, 32'b1010);
    read_a = 1'b0; read_b = 1'b0;
    step(); step();

    // Reset in the middle of a port A access; a stale mem_resp follows.
    forced_delay = 5;
    read_a = 1'b1; address_a = 32'h0000_0100;
    step(); chk("RST busy mem_read", {31'd0, mem_read}, 32'd1);
    step();
    #2 rst = 1'b1; model_reset();
    #1 chk("RST async mem_read", {31'd0, mem_read}, 32'd0);
    read_a = 1'b0;
    step(); #2 rst = 1'b0;
    step(); mem_resp = 1'b1; mem_rdata = 32'h0000_0055;
    step(); chk("RST stale resp_a", {31'd0, resp_a}, 32'd0);
    chk("RST rdata_a", rdata_a, 32'd0);

    // Randomized traffic, conflict-heavy first.
    forced_delay = -1; stale_en = 1'b1;
    a_pend = 1'b0; b_pend = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int pa;
      pa = (cyc < 800) ? 100 : 40;
      if (m_resp == 1) a_pend = 1'b0;
      if (m_resp == 2) b_pend = 1'b0;
      if (!a_pend && $urandom_range(0, 99) < pa) begin
        a_pend = 1'b1;
        address_a = $urandom & 32'hFFFF_FFFC;
      end
      if (!b_pend && $urandom_range(0, 99) < pa) begin
        b_pend = 1'b1;
        kind = $urandom_range(0, 2);
        read_b = (kind != 1); write = (kind != 0);
        address_b = $urandom & 32'hFFFF_FFFC; wdata = $urandom; wmask = 4'($urandom);
      end
      if (!b_pend) begin
        read_b = 1'b0; write = 1'b0;
      end
      read_a = a_pend;
      if (m_owner == 1 && $urandom_range(0, 1) == 1) address_a = $urandom;
      if (m_owner == 2 && $urandom_range(0, 1) == 1) begin
        address_b = $urandom; wdata = $urandom; wmask = 4'($urandom);
      end
      step();
    end
    read_a = 1'b0; read_b = 1'b0; write = 1'b0;
    repeat (8) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Memory-side responder for the pipelined RV32I core's two memory ports.
  - Port A is instruction fetch, read-only.
  - Port B is data, read or write with byte mask.
- Serializes both ports onto one downstream word-level memory/L2 port.
- Returns data together with a single-cycle resp pulse to the port that owns the transaction.
- Port A requests every cycle, so the arbiter alternates between ports. This stops port B from being starved.

Parameters:
- ADDR_WIDTH, 32, width of byte addresses on all ports.
- DATA_WIDTH, 32, data word width; mask width is DATA_WIDTH/8.
- RESET_PRIO_B, 1, port that wins a simultaneous request first after reset (1 = B, 0 = A).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- read_a  in  1  instruction read request; held until resp_a.
- address_a  in  ADDR_WIDTH  instruction address.
- rdata_a  out  DATA_WIDTH  instruction data; valid while resp_a=1.
- resp_a  out  1  one-cycle completion pulse for port A.
- read_b  in  1  data read request; held until resp_b.
- write  in  1  data write request; held until resp_b.
- address_b  in  ADDR_WIDTH  data address.
- wdata  in  DATA_WIDTH  write data.
- wmask  in  DATA_WIDTH/8  byte enables for a write.
- rdata_b  out  DATA_WIDTH  load data; valid while resp_b=1.
- resp_b  out  1  one-cycle completion pulse for port B.
- mem_read  out  1  downstream read strobe.
- mem_write  out  1  downstream write strobe.
- mem_address  out  ADDR_WIDTH  downstream address.
- mem_wdata  out  DATA_WIDTH  downstream write data.
- mem_wmask  out  DATA_WIDTH/8  downstream byte enables.
- mem_rdata  in  DATA_WIDTH  downstream read data; valid with mem_resp.
- mem_resp  in  1  downstream completion, one cycle.
- conflict_cnt  out  32  saturating count of cycles in IDLE with both ports requesting.

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE; last_grant is set to the inverse of RESET_PRIO_B.
  - All outputs are 0, including request registers and conflict_cnt.
- States: IDLE, BUSY_A, BUSY_B, RESP_A, RESP_B.
- IDLE:
  - Only A requests → BUSY_A. Only B requests (read_b|write) → BUSY_B.
  - Both request → grant the port not equal to last_grant, then update last_grant.
  - Neither requests → stay in IDLE.
  - On every grant, capture address, wdata, wmask and opcode into request registers.
  - While both ports request, increment conflict_cnt; it saturates at 32'hFFFFFFFF.
- BUSY_x:
  - mem_read or mem_write is driven from the request registers, not from the live inputs. Inputs may change without effect.
  - Strobes stay high until mem_resp; then latch mem_rdata into the rdata register and go to RESP_x.
- RESP_x:
  - resp_x=1 for exactly one cycle, with rdata_x valid; the strobe is already deasserted.
  - Next state is IDLE, unconditionally.
  - The requester's held request is therefore never re-sampled in the same cycle as its resp.
- Latency: request seen at cycle 0 → strobe from cycle 1 → mem_resp at cycle k → resp at k+1 → new arbitration at k+2.
  - Minimum round trip is 3 cycles, when mem_resp arrives in cycle 1.
- Port B with both read_b and write high is treated as a write. rdata_b is 0 on write responses.
- Port A always reports mem_wmask=0 and mem_write=0.
- mem_resp arriving in IDLE or RESP_x is ignored, e.g. stale after reset.
- Reset mid-transaction: strobes drop immediately (async); the pending response is lost and the requester reissues.
- rdata_a and rdata_b hold their last value between responses.
- resp_a and resp_b are never high in the same cycle.

Decomposition:
- Package mem_arb_types holds:
  - the arb_state_t enum (IDLE, BUSY_A, BUSY_B, RESP_A, RESP_B);
  - the arb_req_t struct (addr, wdata, wmask, rd, wr).
- Sub-module rr_select: combinational two-requester round-robin select.
  - Inputs: req_a, req_b, last_grant.
  - Outputs: grant_a, grant_b.
  - Reusable for a later L2 arbiter.

Test Plan:
- A-only read to 0x0000_0060, memory returns 0x00000013 after 2 cycles:
  - mem_read in cycles 1–2, resp_a in cycle 3 with rdata_a=0x00000013;
  - resp_b stays 0; conflict_cnt=0.
- B write to 0x0000_1004, wdata 0xDEADBEEF, wmask 4'b0011, A idle:
  - mem_write=1, mem_wmask=4'b0011, mem_wdata=0xDEADBEEF;
  - resp_b pulses once; rdata_b=0.
- A and B requesting continuously from reset (RESET_PRIO_B=1), B reading 0x2000:
  - grant order is B, A, B, A;
  - conflict_cnt increments once per IDLE cycle with both pending.
- B changes address_b to 0x3000 while BUSY_B on 0x2000 → mem_address stays 0x2000 until mem_resp.
- rst asserted in BUSY_A mid-transaction:
  - mem_read drops the same cycle, state is IDLE;
  - a mem_resp one cycle after reset release produces no resp_a.
- read_b and write both high → handled as a write (mem_write=1, mem_read=0).
